sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 57 +++++
 tb/tb_sync_fifo_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with wrap-bit pointers, level flags, sticky error flags and optional first-word-fall-through
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0] dout_q;
    logic              wr_ok, rd_ok;
    assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty        = wr_ptr == rd_ptr;
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= (ADDR_W+1)'(AF_LEVEL);
    assign almost_empty = count <= (ADDR_W+1)'(AE_LEVEL);
    assign wr_ok        = wr_en && !full;
    assign rd_ok        = r_en && !empty;
    // FWFT shows the live head word; the register keeps the last consumed word for when the FIFO drains
    assign data_out     = (FWFT && !empty) ? mem[rd_ptr[ADDR_W-1:0]] : dout_q;
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dout_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
            if (wr_en && full) overflow <= 1'b1;
            if (r_en && empty) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of the FIFO in registered-read and first-word-fall-through modes
module tb_sync_fifo_param;
    logic clk = 0;
    always #5 clk = ~clk;

    logic       rst, wr_en, r_en;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_rst, f_wr_en, f_r_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .data_in(f_data_in), .r_en(f_r_en),
        .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; wr_en = 0; r_en = 0; data_in = 0;
        f_rst = 1; f_wr_en = 0; f_r_en = 0; f_data_in = 0;
        step;
        rst = 0; f_rst = 0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_dout", data_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        // fill 1..8 and watch the level flags
        wr_en = 1;
        for (int i = 1; i <= 8; i++) begin
            data_in = 8'(i);
            step;
            check($sformatf("fill_count%0d", i), count, i);
            check($sformatf("fill_ae%0d", i), almost_empty, i <= 1);
            check($sformatf("fill_af%0d", i), almost_full, i >= 6);
            check($sformatf("fill_full%0d", i), full, i == 8);
        end
        data_in = 9;
        step;
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_full", full, 1);
        wr_en = 0; r_en = 1;
        for (int i = 1; i <= 8; i++) begin
            step;
            check($sformatf("drain_dout%0d", i), data_out, i);
            check($sformatf("drain_count%0d", i), count, 8 - i);
        end
        check("drain_empty", empty, 1);
        step;
        r_en = 0;
        check("udf_set", underflow, 1);
        check("udf_dout", data_out, 8);
        check("udf_count", count, 0);
        check("ovf_sticky", overflow, 1);

        // steady-state streaming across pointer wrap
        rst = 1; step; rst = 0;
        wr_en = 1;
        for (int i = 1; i <= 4; i++) begin
            data_in = 8'(i);
            step;
        end
        r_en = 1;
        for (int j = 0; j < 20; j++) begin
            data_in = 8'(j + 5);
            step;
            check($sformatf("stream_count%0d", j), count, 4);
            check($sformatf("stream_dout%0d", j), data_out, j + 1);
        end
        wr_en = 0;
        for (int j = 21; j <= 24; j++) begin
            step;
            check($sformatf("tail_dout%0d", j), data_out, j);
        end
        r_en = 0;
        check("tail_empty", empty, 1);
        check("tail_udf", underflow, 0);

        // full with simultaneous read/write, then reset with pending write
        wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h40 + i);
            step;
        end
        data_in = 8'h99;
        step;
        check("ovf2_set", overflow, 1);
        data_in = 8'hEE; r_en = 1;
        step;
        check("full_rw_count", count, 7);
        check("full_rw_dout", data_out, 8'h40);
        wr_en = 0;
        step;
        step;
        r_en = 0;
        check("mid_count", count, 5);
        check("mid_dout", data_out, 8'h42);
        rst = 1; wr_en = 1; data_in = 8'h77;
        step;
        rst = 0; wr_en = 0;
        check("rst2_count", count, 0);
        check("rst2_empty", empty, 1);
        check("rst2_ovf", overflow, 0);
        check("rst2_dout", data_out, 0);

        // empty with simultaneous read/write
        wr_en = 1; r_en = 1; data_in = 8'h33;
        step;
        wr_en = 0;
        check("empty_rw_count", count, 1);
        check("empty_rw_udf", underflow, 1);
        check("empty_rw_dout", data_out, 0);
        step;
        r_en = 0;
        check("empty_rw_read", data_out, 8'h33);
        check("empty_rw_empty", empty, 1);

        // first-word-fall-through instance
        f_wr_en = 1; f_data_in = 8'hA5;
        step;
        f_wr_en = 0;
        check("fwft_dout", f_data_out, 8'hA5);
        check("fwft_nempty", f_empty, 0);
        step;
        check("fwft_hold", f_data_out, 8'hA5);
        f_r_en = 1;
        step;
        f_r_en = 0;
        check("fwft_empty", f_empty, 1);
        check("fwft_keep", f_data_out, 8'hA5);
        f_wr_en = 1; f_data_in = 8'hB1;
        step;
        f_data_in = 8'hC2;
        step;
        f_wr_en = 0;
        check("fwft_head1", f_data_out, 8'hB1);
        f_r_en = 1;
        step;
        f_r_en = 0;
        check("fwft_head2", f_data_out, 8'hC2);
        check("fwft_count", f_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
